sfx_mixer_player: RTL and testbench
===================================

Name: sfx_mixer_player

Overview:
- Multi-voice successor to the single-clip gunshot player.
- Plays up to NUM_VOICES independent sound clips at once from one shared sample ROM.
- Sums the active voices with saturation and writes one mixed sample to the audio DAC per write-ready request.
- Sits between game-event logic (shot, hit, reload triggers) and the audio codec interface.

Parameters:
- NUM_VOICES, 4, number of independent playback voices.
- SAMPLE_W, 24, signed sample width in ROM and at the DAC.
- ADDR_W, 16, sample ROM address width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- trig  in  NUM_VOICES  one-cycle start/restart pulse per voice.
- voice_base  in  NUM_VOICES*ADDR_W  clip start address per voice; voice i occupies bits [i*ADDR_W +: ADDR_W].
- voice_len  in  NUM_VOICES*ADDR_W  clip length in samples per voice; same packing as voice_base.
- voice_active  out  NUM_VOICES  voice i is currently playing.
- rom_addr  out  ADDR_W  shared sample ROM address.
- rom_q  in  SAMPLE_W  ROM data; valid exactly 1 cycle after rom_addr is presented.
- aud_write_ready  in  1  DAC can accept a sample.
- aud_write  out  1  one-cycle write strobe to DAC.
- aud_write_d  out  SAMPLE_W  mixed sample to DAC.

Behaviour:
- Reset: all voices inactive; FSM enters S_WAIT; aud_write=0; aud_write_d=0; rom_addr=0; accumulator=0. Reset mid-mix aborts the mix; no write is issued.
- Per-voice state: active bit, ptr[ADDR_W], last[ADDR_W].
- trig[i] with voice_len[i]!=0: ptr<=base, last<=base+len-1 (mod 2^ADDR_W), active<=1. A trigger on an already active voice restarts it at base.
- trig[i] with voice_len[i]==0: ignored.
- Triggers are accepted in every FSM state. If a trigger coincides with an advance of the same voice, the trigger wins.
- Mixer FSM:
  - S_WAIT: on aud_write_ready=1, clear acc, v<=0, go to S_ISSUE.
  - S_ISSUE: rom_addr<=ptr[v] if voice v is active, otherwise no ROM use; go to S_CAPTURE.
  - S_CAPTURE: if voice v was active at issue, acc += sign-extended rom_q; then ptr[v]<=ptr+1, or active<=0 if ptr==last. If v==NUM_VOICES-1 go to S_OUT, else v++ and go to S_ISSUE.
  - S_OUT: aud_write_d<=sat(acc). If aud_write_ready=1, pulse aud_write for 1 cycle and go to S_WAIT; otherwise hold in S_OUT.
- Accumulator width: SAMPLE_W+$clog2(NUM_VOICES)+1, signed.
- sat(): clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Latency: aud_write asserts exactly 2*NUM_VOICES+1 cycles after the aud_write_ready edge accepted in S_WAIT, provided ready is still high.
- Each voice advances exactly one sample per DAC write.
- No voices active: every write still occurs, with aud_write_d=0.
- aud_write_d holds its value between writes.
- A voice going inactive in S_CAPTURE contributes its last sample to the current mix only.
- voice_active reflects registered active bits.

Optional Feature:
- Macro: SFX_VOLUME_EN.
- When defined: adds input voice_atten [NUM_VOICES*4]. In S_CAPTURE each sample is arithmetically right-shifted by voice_atten[i] (0 = full scale, 15 = near silence) before accumulation. voice_atten is sampled during S_CAPTURE, not latched at trigger.
- When undefined: the port does not exist and all samples accumulate at full scale.

Test Plan:
- Single voice: voice 0 base=0x0010, len=3, ROM[0x10..0x12]=100,200,-50; trig[0]; 4 ready requests -> writes 100, 200, -50, 0; voice_active[0] drops after the 3rd write.
- Two overlapping voices: voice0 ROM value 1000, voice1 ROM value -300 at the same mix -> write 700; after voice1 ends, writes carry voice0 alone.
- Saturation: 4 voices each reading 0x7FFFFF -> write 0x7FFFFF; 4 voices each reading 0x800000 -> write 0x800000.
- Retrigger: voice 0 len=10 retriggered after its 5th write -> 6th write uses ROM[base]; voice stays active for 10 more writes.
- Handshake/latency: NUM_VOICES=4, ready rises in S_WAIT -> aud_write exactly 9 cycles later. If ready is low when S_OUT is reached -> aud_write stays 0 until ready=1, then a single pulse.
- Reset mid-mix: assert reset in S_CAPTURE -> no aud_write, voice_active=0, aud_write_d=0; next ready -> write 0.

Source files
------------

// File: rtl/sfx_mixer_player.sv
// ============================================================================
// sfx_mixer_player : multi-voice clip player, saturating mix of shared-ROM samples to DAC
// Option macro SFX_VOLUME_EN adds per-voice attenuation.  Rev 1.0
// ============================================================================
`default_nettype none

module sfx_mixer_player #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24,
  parameter int ADDR_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VOICES-1:0]        trig,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
`ifdef SFX_VOLUME_EN
  input  logic [NUM_VOICES*4-1:0]      voice_atten,
`endif
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [SAMPLE_W-1:0]          rom_q,
  input  logic                         aud_write_ready,
  output logic                         aud_write,
  output logic [SAMPLE_W-1:0]          aud_write_d
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int V_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  localparam logic [V_W-1:0] V_LAST = V_W'(NUM_VOICES - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic [V_W-1:0]           v_q, v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
  logic                     issued_q, issued_d;
  logic [SAMPLE_W-1:0]      sample_q, sample_d;
  logic                     aud_write_q, aud_write_nxt;

  logic                     active_q [NUM_VOICES];
  logic                     active_d [NUM_VOICES];
  logic [ADDR_W-1:0]        ptr_q    [NUM_VOICES];
  logic [ADDR_W-1:0]        ptr_d    [NUM_VOICES];
  logic [ADDR_W-1:0]        last_q   [NUM_VOICES];
  logic [ADDR_W-1:0]        last_d   [NUM_VOICES];

  logic signed [SAMPLE_W-1:0] samp;
  logic signed [ACC_W-1:0]    samp_ext;
  logic [SAMPLE_W-1:0]        sat_val;

`ifdef SFX_VOLUME_EN
  always_comb begin
    samp = $signed(rom_q) >>> voice_atten[v_q*4 +: 4];
  end
`else
  always_comb begin
    samp = $signed(rom_q);
  end
`endif

  always_comb begin
    samp_ext = {{(ACC_W-SAMPLE_W){samp[SAMPLE_W-1]}}, samp};
  end

  always_comb begin
    if (acc_q > SAT_MAX) begin
      sat_val = SAT_MAX[SAMPLE_W-1:0];
    end else if (acc_q < SAT_MIN) begin
      sat_val = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_val = acc_q[SAMPLE_W-1:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    acc_d         = acc_q;
    rom_addr_d    = rom_addr_q;
    issued_d      = issued_q;
    sample_d      = sample_q;
    aud_write_nxt = 1'b0;
    active_d      = active_q;
    ptr_d         = ptr_q;
    last_d        = last_q;

    case (state_q)
      S_WAIT: begin
        if (aud_write_ready) begin
          acc_d   = '0;
          v_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issued_d = active_q[v_q];
        if (active_q[v_q]) begin
          rom_addr_d = ptr_q[v_q];
        end
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The last sample of a clip still joins this mix; the voice retires afterwards.
        if (issued_q) begin
          acc_d = acc_q + samp_ext;
          if (ptr_q[v_q] == last_q[v_q]) begin
            active_d[v_q] = 1'b0;
          end else begin
            ptr_d[v_q] = ptr_q[v_q] + ADDR_W'(1);
          end
        end
        if (v_q == V_LAST) begin
          state_d = S_OUT;
        end else begin
          v_d     = v_q + V_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_OUT: begin
        sample_d = sat_val;
        if (aud_write_ready) begin
          aud_write_nxt = 1'b1;
          state_d       = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase

    // Triggers are applied last so a restart overrides a same-cycle advance.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (trig[i] && (voice_len[i*ADDR_W +: ADDR_W] != '0)) begin
        ptr_d[i]    = voice_base[i*ADDR_W +: ADDR_W];
        last_d[i]   = voice_base[i*ADDR_W +: ADDR_W] + voice_len[i*ADDR_W +: ADDR_W]
                      - ADDR_W'(1);
        active_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      v_q         <= '0;
      acc_q       <= '0;
      rom_addr_q  <= '0;
      issued_q    <= 1'b0;
      sample_q    <= '0;
      aud_write_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        active_q[i] <= 1'b0;
        ptr_q[i]    <= '0;
        last_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      rom_addr_q  <= rom_addr_d;
      issued_q    <= issued_d;
      sample_q    <= sample_d;
      aud_write_q <= aud_write_nxt;
      active_q    <= active_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_active
      assign voice_active[g] = active_q[g];
    end
  endgenerate

  assign rom_addr    = rom_addr_q;
  assign aud_write   = aud_write_q;
  assign aud_write_d = sample_q;

endmodule

`default_nettype wire

// File: tb/tb_sfx_mixer_player.sv
// ============================================================================
// tb_sfx_mixer_player : directed self-checking bench for sfx_mixer_player. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sfx_mixer_player;

  localparam int NV  = 4;
  localparam int SW  = 24;
  localparam int AW  = 16;
  localparam int LAT = 2*NV + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NV-1:0]     trig;
  logic [NV*AW-1:0]  voice_base;
  logic [NV*AW-1:0]  voice_len;
`ifdef SFX_VOLUME_EN
  logic [NV*4-1:0]   voice_atten;
`endif
  logic [NV-1:0]     voice_active;
  logic [AW-1:0]     rom_addr;
  logic [SW-1:0]     rom_q;
  logic              aud_write_ready;
  logic              aud_write;
  logic [SW-1:0]     aud_write_d;

  logic [SW-1:0]     mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  assign rom_q = mem[rom_addr];

  sfx_mixer_player #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .trig            (trig),
    .voice_base      (voice_base),
    .voice_len       (voice_len),
`ifdef SFX_VOLUME_EN
    .voice_atten     (voice_atten),
`endif
    .voice_active    (voice_active),
    .rom_addr        (rom_addr),
    .rom_q           (rom_q),
    .aud_write_ready (aud_write_ready),
    .aud_write       (aud_write),
    .aud_write_d     (aud_write_d)
  );

  always @(posedge clk) begin
    if (aud_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic trigger(input int i, input logic [AW-1:0] base, input logic [AW-1:0] len);
    @(negedge clk);
    voice_base[i*AW +: AW] = base;
    voice_len[i*AW +: AW]  = len;
    trig    = '0;
    trig[i] = 1'b1;
    @(negedge clk);
    trig = '0;
  endtask

  // One full ready request with ready held high: checks latency, data and single pulse.
  task automatic do_write(input string tag, input logic [SW-1:0] exp);
    int   k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    @(negedge clk);
    aud_write_ready = 1'b1;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = aud_write;
    end
    aud_write_ready = 1'b0;
    check({tag, "_lat"}, 32'(k - 1), 32'(LAT));
    check(tag, 32'(aud_write_d), 32'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(aud_write), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   k;
    logic seen;
    for (int a = 0; a < 65536; a++) mem[a] = SW'((a & 255) + 3);
    mem[16'h0010] = 24'd100;
    mem[16'h0011] = 24'd200;
    mem[16'h0012] = 24'(-50);
    for (int j = 0; j < 4; j++) mem[16'h0100 + j] = 24'd1000;
    for (int j = 0; j < 2; j++) mem[16'h0200 + j] = 24'(-300);
    mem[16'h0300] = 24'h7FFFFF;
    mem[16'h0301] = 24'h800000;
    for (int j = 0; j < 10; j++) mem[16'h0400 + j] = SW'(1000 + 10*j);
    mem[16'h0500] = 24'd1234;
    mem[16'h0600] = 24'd77;

    reset = 1'b1; trig = '0; voice_base = '0; voice_len = '0; aud_write_ready = 1'b0;
`ifdef SFX_VOLUME_EN
    voice_atten = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_active", 32'(voice_active), 32'd0);
    check("rst_write", 32'(aud_write), 32'd0);
    check("rst_data", 32'(aud_write_d), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;

    do_write("idle", 24'd0);

    // Single voice
    trigger(0, 16'h0010, 16'd3);
    check("sv_active0", 32'(voice_active), 32'b0001);
    do_write("sv_w1", 24'd100);
    do_write("sv_w2", 24'd200);
    check("sv_active2", 32'(voice_active), 32'b0001);
    do_write("sv_w3", 24'(-50));
    check("sv_active3", 32'(voice_active), 32'd0);
    do_write("sv_w4", 24'd0);

    // Two overlapping voices
    trigger(0, 16'h0100, 16'd4);
    trigger(1, 16'h0200, 16'd2);
    do_write("ov_w1", 24'd700);
    do_write("ov_w2", 24'd700);
    check("ov_active", 32'(voice_active), 32'b0001);
    do_write("ov_w3", 24'd1000);
    do_write("ov_w4", 24'd1000);
    check("ov_done", 32'(voice_active), 32'd0);

    // Saturation and signed mix
    for (int i = 0; i < NV; i++) trigger(i, 16'h0300, 16'd1);
    do_write("sat_pos", 24'h7FFFFF);
    for (int i = 0; i < NV; i++) trigger(i, 16'h0301, 16'd1);
    do_write("sat_neg", 24'h800000);
    trigger(0, 16'h0300, 16'd1);
    trigger(1, 16'h0301, 16'd1);
    do_write("mix_m1", 24'hFFFFFF);

    // Zero-length trigger is ignored
    trigger(3, 16'h0300, 16'd0);
    check("len0_active", 32'(voice_active), 32'd0);
    do_write("len0_w", 24'd0);

    // Retrigger after 5th write restarts at base for 10 more writes
    trigger(0, 16'h0400, 16'd10);
    for (int j = 0; j < 5; j++) do_write("rt_pre", SW'(1000 + 10*j));
    trigger(0, 16'h0400, 16'd10);
    for (int j = 0; j < 10; j++) begin
      do_write("rt_post", SW'(1000 + 10*j));
      if (j == 8) check("rt_active9", 32'(voice_active), 32'b0001);
    end
    check("rt_done", 32'(voice_active), 32'd0);

    // Ready drops before S_OUT: no write until ready returns, then exactly one
    trigger(2, 16'h0500, 16'd1);
    @(negedge clk);
    aud_write_ready = 1'b1;
    c0 = wr_cnt;
    @(negedge clk);
    aud_write_ready = 1'b0;
    repeat (15) @(negedge clk);
    check("stall_nowrite", 32'(wr_cnt - c0), 32'd0);
    check("stall_data", 32'(aud_write_d), 32'd1234);
    aud_write_ready = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      seen = aud_write;
    end
    aud_write_ready = 1'b0;
    check("stall_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("stall_count", 32'(wr_cnt - c0), 32'd1);
    check("stall_pulse", 32'(aud_write), 32'd0);
    repeat (5) @(negedge clk);
    check("hold_data", 32'(aud_write_d), 32'd1234);

    // Reset while the mixer is in S_CAPTURE
    trigger(1, 16'h0600, 16'd5);
    @(negedge clk);
    aud_write_ready = 1'b1;
    c0 = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    aud_write_ready = 1'b0;
    @(negedge clk);
    check("mrst_active", 32'(voice_active), 32'd0);
    check("mrst_data", 32'(aud_write_d), 32'd0);
    check("mrst_write", 32'(aud_write), 32'd0);
    check("mrst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("mrst_nowrite", 32'(wr_cnt - c0), 32'd0);
    do_write("mrst_next", 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
